// File: rtl/alu_command_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_command_issuer_if
// Purpose  : Bundles the three channels around the ALU command issuer:
//              - command channel  (CmdValid/CmdReady + operation fields)
//              - ALU drive bus    (A, B, FunSel, WF out; ALUOut, FlagsOut in)
//              - response channel (RspValid/RspReady + result, flags, skip)
// Modports : slave  - the issuer itself (accepts commands, drives the ALU,
//                     produces responses)
//            master - the surroundings (control unit / bench plus the ALU)
// Ports    : none; the interface is a pure signal bundle.
// Revision : 1.0  initial release
// ============================================================================
interface alu_command_issuer_if;

  // Command channel
  logic        CmdValid;
  logic        CmdReady;
  logic [4:0]  CmdFunSel;
  logic [15:0] CmdA;
  logic [15:0] CmdB;
  logic        CmdWF;
  logic [2:0]  CmdCond;

  // ALU drive / return
  logic [15:0] A;
  logic [15:0] B;
  logic [4:0]  FunSel;
  logic        WF;
  logic [15:0] ALUOut;
  logic [3:0]  FlagsOut;   // {Z,C,N,O}

  // Response channel
  logic        RspValid;
  logic        RspReady;
  logic [15:0] RspData;
  logic [3:0]  RspFlags;   // {Z,C,N,O}
  logic        RspSkipped;

  modport slave (
    input  CmdValid, CmdFunSel, CmdA, CmdB, CmdWF, CmdCond,
    output CmdReady,
    output A, B, FunSel, WF,
    input  ALUOut, FlagsOut,
    output RspValid, RspData, RspFlags, RspSkipped,
    input  RspReady
  );

  modport master (
    output CmdValid, CmdFunSel, CmdA, CmdB, CmdWF, CmdCond,
    input  CmdReady,
    input  A, B, FunSel, WF,
    output ALUOut, FlagsOut,
    input  RspValid, RspData, RspFlags, RspSkipped,
    output RspReady
  );

endinterface
`default_nettype wire

// File: rtl/alu_command_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_command_issuer
// Purpose  : Initiator-side controller for the ALU. Accepts one command over
//            a valid/ready handshake, presents it to the ALU for exactly one
//            clock (ISSUE), waits one clock for the registered flags to
//            settle (SETTLE), then returns result and flags over a second
//            valid/ready handshake (RESP). A command whose condition code is
//            false on the live flags is skipped: WF is never raised, the
//            result reads zero and the response carries RspSkipped = 1.
// Ports    : Clock  - rising-edge system clock
//            Reset  - asynchronous, active-low reset
//            bus    - alu_command_issuer_if.slave: command channel, ALU drive
//                     bus (A/B/FunSel/WF out, ALUOut/FlagsOut in) and
//                     response channel
// Revision : 1.0  initial release
// ============================================================================
module alu_command_issuer (
  input  logic                 Clock,
  input  logic                 Reset,
  alu_command_issuer_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Condition codes; flags are ordered {Z,C,N,O}
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_condAlways = 3'd0;
  localparam logic [2:0] c_condZ      = 3'd1;
  localparam logic [2:0] c_condNotZ   = 3'd2;
  localparam logic [2:0] c_condC      = 3'd3;
  localparam logic [2:0] c_condNotC   = 3'd4;
  localparam logic [2:0] c_condN      = 3'd5;
  localparam logic [2:0] c_condNotN   = 3'd6;
  localparam logic [2:0] c_condO      = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } issuerState_t;

  issuerState_t r_state;
  issuerState_t w_nextState;

  // Latched command
  logic [4:0]  r_funSel;
  logic [15:0] r_opA;
  logic [15:0] r_opB;
  logic        r_wf;
  logic [2:0]  r_cond;

  // Response payload
  logic [15:0] r_rspData;
  logic [3:0]  r_rspFlags;
  logic        r_rspSkipped;

  // FSM decoded controls
  logic        w_cmdReady;
  logic        w_rspValid;
  logic        w_driveAlu;
  logic        w_wf;
  logic        w_accept;

  // Datapath helpers
  logic        w_flagZ;
  logic        w_flagC;
  logic        w_flagN;
  logic        w_flagO;
  logic        w_condOk;
  logic [15:0] w_result;

  // --------------------------------------------------------------------------
  // Condition evaluation against the live ALU flags
  // --------------------------------------------------------------------------
  assign w_flagZ = bus.FlagsOut[3];
  assign w_flagC = bus.FlagsOut[2];
  assign w_flagN = bus.FlagsOut[1];
  assign w_flagO = bus.FlagsOut[0];

  always_comb begin
    w_condOk = 1'b0;
    case (r_cond)
      c_condAlways: w_condOk = 1'b1;
      c_condZ:      w_condOk = w_flagZ;
      c_condNotZ:   w_condOk = !w_flagZ;
      c_condC:      w_condOk = w_flagC;
      c_condNotC:   w_condOk = !w_flagC;
      c_condN:      w_condOk = w_flagN;
      c_condNotN:   w_condOk = !w_flagN;
      c_condO:      w_condOk = w_flagO;
      default:      w_condOk = 1'b0;
    endcase
  end

  // 8-bit operations (FunSel[4] = 0) only define the low byte of ALUOut;
  // the upper byte is forced to zero so the response is zero-extended.
  assign w_result = r_funSel[4] ? bus.ALUOut : {8'h00, bus.ALUOut[7:0]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    w_cmdReady  = 1'b0;
    w_rspValid  = 1'b0;
    w_driveAlu  = 1'b0;
    w_wf        = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmdReady = 1'b1;
        if (bus.CmdValid) begin
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_driveAlu  = 1'b1;
        w_wf        = r_wf && w_condOk;
        w_nextState = SETTLE;
      end
      SETTLE: begin
        // Operands stay on the bus so ALUOut is still meaningful, but WF is
        // low: the flag register was already written at the ISSUE edge.
        w_driveAlu  = 1'b1;
        w_nextState = RESP;
      end
      RESP: begin
        w_rspValid = 1'b1;
        if (bus.RspReady) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_accept = w_cmdReady && bus.CmdValid;

  // --------------------------------------------------------------------------
  // Command latch and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_funSel     <= 5'b00000;
      r_opA        <= 16'h0000;
      r_opB        <= 16'h0000;
      r_wf         <= 1'b0;
      r_cond       <= 3'd0;
      r_rspData    <= 16'h0000;
      r_rspFlags   <= 4'b0000;
      r_rspSkipped <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funSel <= bus.CmdFunSel;
        r_opA    <= bus.CmdA;
        r_opB    <= bus.CmdB;
        r_wf     <= bus.CmdWF;
        r_cond   <= bus.CmdCond;
      end
      if (r_state == ISSUE) begin
        r_rspData    <= w_condOk ? w_result : 16'h0000;
        r_rspSkipped <= !w_condOk;
      end
      // FlagsOut is registered inside the ALU, so the ISSUE-cycle update is
      // only visible one cycle later; capture it at the end of SETTLE.
      if (r_state == SETTLE) begin
        r_rspFlags <= bus.FlagsOut;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The ALU bus is decoded straight from the state register so an
  // asynchronous reset clears A/B/FunSel/WF immediately.
  // --------------------------------------------------------------------------
  assign bus.CmdReady   = w_cmdReady;
  assign bus.A          = w_driveAlu ? r_opA    : 16'h0000;
  assign bus.B          = w_driveAlu ? r_opB    : 16'h0000;
  assign bus.FunSel     = w_driveAlu ? r_funSel : 5'b00000;
  assign bus.WF         = w_wf;
  assign bus.RspValid   = w_rspValid;
  assign bus.RspData    = r_rspData;
  assign bus.RspFlags   = r_rspFlags;
  assign bus.RspSkipped = r_rspSkipped;

endmodule
`default_nettype wire
